imm_encode_seq: RTL and testbench
=================================

IMM_ENCODE_SEQ -- requirements
Module: imm_encode_seq

Interface
REQ-001 Parameter WORD_LENGTH, default 24, instruction and data word width; bit 0 is the MSB.
REQ-002 Parameter REG_BITS, default 4, target general register field width.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1  request present.
REQ-006 Port in_ready  output  1  unit accepts request this cycle.
REQ-007 Port in_value  input  WORD_LENGTH  constant to materialise.
REQ-008 Port in_reg  input  REG_BITS  target register number.
REQ-009 Port out_valid  output  1  out_instr holds a valid instruction word.
REQ-010 Port out_ready  input  1  consumer takes out_instr this cycle.
REQ-011 Port out_instr  output  WORD_LENGTH  encoded instruction: opcode [0:5], r [6:9], imm [10:23].
REQ-012 Port out_last  output  1  out_instr is the final word of the current sequence.

Function
REQ-013 Unit SHALL be the encoder counterpart of ImmGenUnit: every emitted sequence, decoded through ImmGenUnit and executed, SHALL leave in_value in register in_reg.
REQ-014 Short form: if in_value[0:10] are all equal (fits signed 14-bit), SHALL emit one word LDI: opcode OP_LDI, r=in_reg, imm=in_value[10:23], out_last=1.
REQ-015 Long form: otherwise SHALL emit LDIL (opcode OP_LDIL, imm=in_value[0:13]) with out_last=0, then ORIL (opcode OP_ORIL, imm[10:13]=0, imm[14:23]=in_value[14:23]) with out_last=1.
REQ-016 FSM states IDLE, EMIT_FIRST, EMIT_SECOND; encoding from shared package.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid SHALL capture in_value/in_reg into holding registers and go to EMIT_FIRST.
REQ-018 EMIT_FIRST: out_valid=1, first word from holding registers; on out_ready go to IDLE (short form) or EMIT_SECOND (long form); else hold.
REQ-019 EMIT_SECOND: out_valid=1, ORIL word; on out_ready go to IDLE; else hold.
REQ-020 Latency: first word valid one cycle after acceptance; each following word valid the cycle after the previous one is consumed.
REQ-021 Back-to-back: in_ready SHALL be 1 also in the cycle out_last is consumed, so a new request can be accepted in that same cycle with no bubble.
REQ-022 While out_valid=1 and out_ready=0, out_instr and out_last SHALL stay stable.
REQ-023 Input changes while in_ready=0 SHALL NOT affect emitted words.
REQ-024 in_value=0x001FFF and 0xFFE000 are short form; 0x002000 and 0xFFDFFF are long form.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, out_valid=0, out_last=0, out_instr=0, and clear holding registers; in_ready=0 while rst is high.
REQ-026 Reset mid-sequence SHALL discard the pending word(s); the first cycle after deassertion is IDLE with in_ready=1.

Structure
REQ-027 Shared package SHALL hold WORD_LENGTH, opcode constants OP_LDI, OP_LDIL, OP_ORIL, field bit positions, and FSM state encodings; ImmGenUnit uses the same opcode constants.
REQ-028 One natural sub-module: imm_fit_check (combinational signed-14-bit range test); the rest stays in imm_encode_seq.

Verification
REQ-029 Short form: in_value=0x000005, in_reg=3, out_ready=1 -> one word, OP_LDI, r=3, imm=0x0005, out_last=1, next cycle in_ready=1.
REQ-030 Long form: in_value=0x123456, in_reg=7 -> LDIL imm=0x048D (in_value[0:13]) with out_last=0, then ORIL imm=0x0056 with out_last=1; ImmGenUnit plus register model yields 0x123456.
REQ-031 Boundaries: 0x001FFF, 0xFFE000 -> single word each; 0x002000, 0xFFDFFF -> two words each; ImmGenUnit round-trip matches.
REQ-032 Backpressure: long form with out_ready=0 for 5 cycles in each EMIT state -> words held stable, no loss, no duplication.
REQ-033 Streaming: 100 random requests, out_ready random 50% -> emitted sequence decodes to exactly the request list in order, no bubbles when out_ready=1 throughout.
REQ-034 Reset in EMIT_SECOND: pulse rst asynchronously mid-cycle -> out_valid drops without waiting for clk; after release, new request 0x000001 emitted correctly.

Source files
------------

// File: rtl/imm_encode_seq_pkg.sv
// rtl/imm_encode_seq_pkg.sv - shared constants, opcodes and FSM encoding for the immediate encoder
package imm_encode_seq_pkg;

    localparam int WORD_LENGTH = 24;
    localparam int REG_BITS    = 4;
    localparam int OPCODE_BITS = 6;

    // Field positions, MSB-first numbering (bit 0 is the word MSB)
    localparam int OPCODE_POS = 0;
    localparam int REG_POS    = 6;
    localparam int IMM_POS    = 10;

    localparam logic [OPCODE_BITS-1:0] OP_LDI  = 6'h11;
    localparam logic [OPCODE_BITS-1:0] OP_LDIL = 6'h12;
    localparam logic [OPCODE_BITS-1:0] OP_ORIL = 6'h13;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        EMIT_FIRST  = 2'd1,
        EMIT_SECOND = 2'd2
    } seq_state_e;

endpackage

// File: rtl/imm_encode_seq_fit_check.sv
// rtl/imm_encode_seq_fit_check.sv - combinational test whether a word fits the signed short immediate
module imm_fit_check #(
    parameter int WORD_LENGTH = 24,
    parameter int IMM_BITS    = 14
) (
    input  logic [WORD_LENGTH-1:0] value,
    output logic                   fits
);
    localparam int TOP_BITS = WORD_LENGTH - IMM_BITS + 1;

    logic [TOP_BITS-1:0] top;

    // Sign-extension bits plus the immediate's own sign bit must all agree
    assign top  = value[WORD_LENGTH-1 -: TOP_BITS];
    assign fits = (top == '0) || (top == '1);

endmodule

// File: rtl/imm_encode_seq.sv
// rtl/imm_encode_seq.sv - turns a constant into an LDI or an LDIL/ORIL instruction sequence
module imm_encode_seq #(
    parameter int WORD_LENGTH = imm_encode_seq_pkg::WORD_LENGTH,
    parameter int REG_BITS    = imm_encode_seq_pkg::REG_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] in_value,
    input  logic [REG_BITS-1:0]    in_reg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] out_instr,
    output logic                   out_last
);
    import imm_encode_seq_pkg::*;

    localparam int IMM_BITS = WORD_LENGTH - OPCODE_BITS - REG_BITS;
    localparam int LOW_BITS = WORD_LENGTH - IMM_BITS;
    localparam int PAD_BITS = IMM_BITS - LOW_BITS;

    seq_state_e            state;
    logic [LOW_BITS-1:0]   hold_low;
    logic [REG_BITS-1:0]   hold_reg;
    logic                  fits;
    logic                  accept;
    logic [WORD_LENGTH-1:0] first_word;
    logic [WORD_LENGTH-1:0] second_word;

    imm_fit_check #(
        .WORD_LENGTH (WORD_LENGTH),
        .IMM_BITS    (IMM_BITS)
    ) u_fit (
        .value (in_value),
        .fits  (fits)
    );

    // Ready in IDLE and also while the final word is being taken, so streams have no bubble
    assign in_ready = !rst && ((state == IDLE) || (out_valid && out_last && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        first_word = {OP_LDIL, in_reg, in_value[WORD_LENGTH-1 -: IMM_BITS]};
        if (fits) begin
            first_word = {OP_LDI, in_reg, in_value[IMM_BITS-1:0]};
        end
    end

    assign second_word = {OP_ORIL, hold_reg, {PAD_BITS{1'b0}}, hold_low};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_instr <= '0;
            hold_low  <= '0;
            hold_reg  <= '0;
        end else if (accept) begin
            hold_low  <= in_value[LOW_BITS-1:0];
            hold_reg  <= in_reg;
            out_instr <= first_word;
            out_last  <= fits;
            out_valid <= 1'b1;
            state     <= EMIT_FIRST;
        end else begin
            case (state)
                IDLE: ;
                EMIT_FIRST, EMIT_SECOND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            state     <= EMIT_SECOND;
                            out_instr <= second_word;
                            out_last  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encode_seq.sv
// tb/tb_imm_encode_seq.sv - randomized self-checking bench with an instruction-level reference model
module tb_imm_encode_seq;
    import imm_encode_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_value;
    logic [3:0]  in_reg;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_instr;
    logic        out_last;

    logic        s_in_ready;
    logic        s_ov;
    logic [23:0] s_oi;
    logic        s_ol;

    int n_vec;
    int n_err;

    logic [23:0] regfile [16];

    typedef struct {
        logic [23:0] w;
        logic        last;
        logic [23:0] val;
        logic [3:0]  r;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] req_val[$];
    logic [3:0]  req_reg[$];

    imm_encode_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_reg    (in_reg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_short(input logic [23:0] v);
        int s;
        s = int'($signed(v));
        return (s >= -8192) && (s <= 8191);
    endfunction

    function automatic int n_words(input logic [23:0] v);
        return is_short(v) ? 1 : 2;
    endfunction

    function automatic logic [23:0] word_of(input logic [23:0] v, input logic [3:0] r, input int idx);
        logic [23:0] rr;
        rr = {20'd0, r};
        if (is_short(v)) return (24'(OP_LDI) << 18) | (rr << 14) | (v & 24'h003FFF);
        if (idx == 0)    return (24'(OP_LDIL) << 18) | (rr << 14) | (v >> 10);
        return (24'(OP_ORIL) << 18) | (rr << 14) | (v & 24'h0003FF);
    endfunction

    function automatic logic [23:0] rand_value();
        case ($urandom % 3)
            0:       return 24'($urandom_range(0, 16383) - 8192);
            1:       return 24'($urandom);
            default: return 24'(($urandom % 2 ? 8192 : -8193) + $urandom_range(0, 3) - 1);
        endcase
    endfunction

    // Executes one instruction the way the decoder/register file would
    task automatic exec_word(input logic [23:0] w);
        int op, r, imm;
        op  = int'(w >> 18);
        r   = int'((w >> 14) & 24'hF);
        imm = int'(w & 24'h3FFF);
        if (op == int'(OP_LDI))       regfile[r] = (imm >= 8192) ? 24'(imm - 16384) : 24'(imm);
        else if (op == int'(OP_LDIL)) regfile[r] = 24'(imm << 10);
        else if (op == int'(OP_ORIL)) regfile[r] = regfile[r] | 24'(imm & 'h3FF);
    endtask

    task automatic cycle(input logic v, input logic [23:0] val, input logic [3:0] r, input logic ordy);
        in_valid  = v;
        in_value  = val;
        in_reg    = r;
        out_ready = ordy;
        #1;
        s_in_ready = in_ready;
        s_ov       = out_valid;
        s_oi       = out_instr;
        s_ol       = out_last;
        @(negedge clk);
    endtask

    task automatic build_requests(input int n);
        req_val.delete();
        req_reg.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [23:0] v;
            logic [3:0]  r;
            v = rand_value();
            r = 4'($urandom);
            req_val.push_back(v);
            req_reg.push_back(r);
            for (int k = 0; k < n_words(v); k++)
                exp_q.push_back('{w: word_of(v, r, k), last: (k == n_words(v) - 1), val: v, r: r});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_value = '0; in_reg = '0; out_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_vec++; if (out_instr !== 24'h0) begin n_err++; $display("FAIL reset_out_instr: got %h want 000000", out_instr); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        cycle(1'b0, 24'h0, 4'h0, 1'b0);
        n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", s_in_ready); end
    endtask

    task automatic test_short();
        cycle(1'b1, 24'h000005, 4'd3, 1'b1);
        n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL short_accept: got %b want 1", s_in_ready); end
        cycle(1'b0, 24'hABCDEF, 4'd9, 1'b1);
        n_vec++; if (s_ov !== 1'b1) begin n_err++; $display("FAIL short_valid: got %b want 1", s_ov); end
        n_vec++; if (s_oi !== ((24'(OP_LDI) << 18) | (24'd3 << 14) | 24'd5)) begin n_err++; $display("FAIL short_word: got %h want LDI r3 0005", s_oi); end
        n_vec++; if (s_ol !== 1'b1) begin n_err++; $display("FAIL short_last: got %b want 1", s_ol); end
        cycle(1'b0, 24'h0, 4'd0, 1'b1);
        n_vec++; if (s_ov !== 1'b0 || s_in_ready !== 1'b1) begin n_err++; $display("FAIL short_after: valid %b ready %b want 0 1", s_ov, s_in_ready); end
    endtask

    task automatic test_long();
        cycle(1'b1, 24'h123456, 4'd7, 1'b1);
        cycle(1'b0, 24'h0, 4'd0, 1'b1);
        n_vec++; if (s_oi !== ((24'(OP_LDIL) << 18) | (24'd7 << 14) | 24'h048D) || s_ol !== 1'b0 || s_ov !== 1'b1) begin
            n_err++; $display("FAIL long_first: got %h last %b valid %b want LDIL r7 048D last 0", s_oi, s_ol, s_ov); end
        exec_word(s_oi);
        cycle(1'b0, 24'h0, 4'd0, 1'b1);
        n_vec++; if (s_oi !== ((24'(OP_ORIL) << 18) | (24'd7 << 14) | 24'h0056) || s_ol !== 1'b1 || s_ov !== 1'b1) begin
            n_err++; $display("FAIL long_second: got %h last %b valid %b want ORIL r7 0056 last 1", s_oi, s_ol, s_ov); end
        exec_word(s_oi);
        n_vec++; if (regfile[7] !== 24'h123456) begin n_err++; $display("FAIL long_roundtrip: got %h want 123456", regfile[7]); end
    endtask

    task automatic test_boundaries();
        logic [23:0] vals [4];
        vals = '{24'h001FFF, 24'hFFE000, 24'h002000, 24'hFFDFFF};
        for (int i = 0; i < 4; i++) begin
            int nw;
            bit done;
            logic [3:0] r;
            r = 4'(i + 1);
            nw = 0; done = 0;
            cycle(1'b1, vals[i], r, 1'b1);
            for (int k = 0; k < 4 && !done; k++) begin
                cycle(1'b0, 24'h0, 4'h0, 1'b1);
                if (s_ov) begin
                    n_vec++; if (s_oi !== word_of(vals[i], r, nw)) begin n_err++; $display("FAIL bound_word %h[%0d]: got %h want %h", vals[i], nw, s_oi, word_of(vals[i], r, nw)); end
                    exec_word(s_oi);
                    nw++;
                    if (s_ol) done = 1;
                end
            end
            n_vec++; if (nw != n_words(vals[i]) || !done) begin n_err++; $display("FAIL bound_count %h: got %0d words want %0d", vals[i], nw, n_words(vals[i])); end
            n_vec++; if (regfile[r] !== vals[i]) begin n_err++; $display("FAIL bound_roundtrip: got %h want %h", regfile[r], vals[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] v;
        v = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
        cycle(1'b1, v, 4'd5, 1'b0);
        for (int k = 0; k < 2; k++) begin
            for (int h = 0; h < 5; h++) begin
                cycle(1'b0, 24'($urandom), 4'($urandom), 1'b0);
                n_vec++; if (s_ov !== 1'b1 || s_oi !== word_of(v, 4'd5, k) || s_ol !== (k == 1)) begin
                    n_err++; $display("FAIL bp_hold%0d: got %h last %b valid %b want %h", k, s_oi, s_ol, s_ov, word_of(v, 4'd5, k)); end
            end
            cycle(1'b0, 24'($urandom), 4'($urandom), 1'b1);
            n_vec++; if (s_ov !== 1'b1 || s_oi !== word_of(v, 4'd5, k)) begin
                n_err++; $display("FAIL bp_take%0d: got %h valid %b want %h", k, s_oi, s_ov, word_of(v, 4'd5, k)); end
        end
        cycle(1'b0, 24'h0, 4'h0, 1'b1);
        n_vec++; if (s_ov !== 1'b0) begin n_err++; $display("FAIL bp_dup: got valid %b want 0", s_ov); end
    endtask

    task automatic test_streaming();
        int sent, cyc;
        build_requests(100);
        sent = 0; cyc = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            logic v, ordy;
            exp_t e;
            v = (sent < 100);
            ordy = 1'($urandom % 2);
            cycle(v, v ? req_val[sent] : 24'($urandom), v ? req_reg[sent] : 4'($urandom), ordy);
            cyc++;
            if (v && s_in_ready) sent++;
            if (s_ov && ordy) begin
                e = exp_q.pop_front();
                n_vec++; if (s_oi !== e.w || s_ol !== e.last) begin n_err++; $display("FAIL stream_word: got %h last %b want %h last %b", s_oi, s_ol, e.w, e.last); end
                exec_word(s_oi);
                if (e.last) begin
                    n_vec++; if (regfile[e.r] !== e.val) begin n_err++; $display("FAIL stream_roundtrip: got %h want %h", regfile[e.r], e.val); end
                end
            end
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_timeout: got %0d words left want 0", exp_q.size()); end
        cycle(1'b0, 24'h0, 4'h0, 1'b1);
        n_vec++; if (s_ov !== 1'b0) begin n_err++; $display("FAIL stream_extra: got valid %b want 0", s_ov); end
    endtask

    task automatic test_no_bubble();
        int sent, cyc, bubbles;
        bit started;
        build_requests(30);
        sent = 0; cyc = 0; bubbles = 0; started = 0;
        while (exp_q.size() > 0 && cyc < 500) begin
            logic v;
            exp_t e;
            v = (sent < 30);
            cycle(v, v ? req_val[sent] : 24'h0, v ? req_reg[sent] : 4'h0, 1'b1);
            cyc++;
            if (v && s_in_ready) sent++;
            if (s_ov) begin
                started = 1;
                e = exp_q.pop_front();
                n_vec++; if (s_oi !== e.w) begin n_err++; $display("FAIL b2b_word: got %h want %h", s_oi, e.w); end
            end else if (started) begin
                bubbles++;
            end
        end
        n_vec++; if (bubbles != 0 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_bubbles: got %0d bubbles %0d left want 0 0", bubbles, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 24'h123456, 4'd9, 1'b1);
        cycle(1'b0, 24'h0, 4'h0, 1'b1);
        #1;
        n_vec++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got valid %b last %b want 1 1", out_valid, out_last); end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_instr !== 24'h0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL rmid_async: got valid %b last %b instr %h ready %b want 0 0 000000 0", out_valid, out_last, out_instr, in_ready); end
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 24'h000001, 4'd2, 1'b1);
        n_vec++; if (s_in_ready !== 1'b1 || s_ov !== 1'b0) begin n_err++; $display("FAIL rmid_idle: got ready %b valid %b want 1 0", s_in_ready, s_ov); end
        cycle(1'b0, 24'h0, 4'h0, 1'b1);
        n_vec++; if (s_ov !== 1'b1 || s_oi !== word_of(24'h000001, 4'd2, 0) || s_ol !== 1'b1) begin
            n_err++; $display("FAIL rmid_new: got %h last %b valid %b want %h", s_oi, s_ol, s_ov, word_of(24'h000001, 4'd2, 0)); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) regfile[i] = '0;
        test_reset();
        test_short();
        test_long();
        test_boundaries();
        test_backpressure();
        test_streaming();
        test_no_bubble();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
